// File: rtl/motion_pkg.sv
// Shared types and constants for the motion segment queue.
package motion_pkg;

  localparam int VEL_W            = 32;
  localparam int DUR_W            = 16;
  localparam int TICK_DIV_DEFAULT = 1000;

  typedef struct packed {
    logic signed [VEL_W-1:0] velocity;
    logic [DUR_W-1:0]        duration;
  } segment_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A zero-length segment still occupies one full tick.
  function automatic logic [DUR_W-1:0] load_duration(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? DUR_W'(1) : dur;
  endfunction

endpackage

// File: rtl/motion_queue_if.sv
// Host-side segment write channel: velocity/duration with a valid/ready handshake.
interface motion_queue_if;
  import motion_pkg::*;

  logic signed [VEL_W-1:0] wr_velocity;
  logic [DUR_W-1:0]        wr_duration;
  logic                    wr_valid;
  logic                    wr_ready;

  modport master (
    output wr_velocity,
    output wr_duration,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_velocity,
    input  wr_duration,
    input  wr_valid,
    output wr_ready
  );

endinterface

// File: rtl/seg_fifo.sv
// Synchronous segment FIFO with wrap-around pointers, flush and occupancy count.
module seg_fifo
  import motion_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  segment_t push_data,
  output segment_t head,
  output logic     full,
  output logic     empty,
  output logic [AW:0] level
);

  segment_t    mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] level_reg;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra bit so full and empty differ when the indices match.
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign level   = level_reg;

  // Head is read combinationally so a pop and the next load share one edge.
  assign head = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/motion_queue.sv
// Segment sequencer: holds each queued velocity for duration*TICK_DIV cycles, back to back.
module motion_queue
  import motion_pkg::*;
#(
  parameter int  DEPTH    = 16,
  parameter int  TICK_DIV = TICK_DIV_DEFAULT,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  motion_queue_if.slave           wr,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    clear_underrun,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    busy,
  output logic                    seg_done,
  output logic                    underrun,
  output logic [LVL_W-1:0]        level
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t                  state_reg, state_next;
  logic [TICK_W-1:0]       tick_cnt_reg, tick_cnt_next;
  logic [DUR_W-1:0]        remaining_reg, remaining_next;
  logic signed [VEL_W-1:0] velocity_reg, velocity_next;
  logic                    busy_reg, busy_next;
  logic                    seg_done_reg, seg_done_next;
  logic                    underrun_reg, underrun_next;
  logic                    underrun_set;

  logic     fifo_pop;
  logic     fifo_flush;
  logic     fifo_full;
  logic     fifo_empty;
  segment_t fifo_head;
  segment_t push_data;

  assign push_data.velocity = wr.wr_velocity;
  assign push_data.duration = wr.wr_duration;
  assign wr.wr_ready        = !fifo_full;

  seg_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (wr.wr_valid),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .push_data(push_data),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  always_comb begin
    state_next     = state_reg;
    tick_cnt_next  = tick_cnt_reg;
    remaining_next = remaining_reg;
    velocity_next  = velocity_reg;
    busy_next      = busy_reg;
    seg_done_next  = 1'b0;
    underrun_set   = 1'b0;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;

    if (abort) begin
      fifo_flush     = 1'b1;
      state_next     = IDLE;
      tick_cnt_next  = '0;
      remaining_next = '0;
      velocity_next  = '0;
      busy_next      = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !fifo_empty) begin
            fifo_pop       = 1'b1;
            velocity_next  = fifo_head.velocity;
            remaining_next = load_duration(fifo_head.duration);
            tick_cnt_next  = '0;
            busy_next      = 1'b1;
            state_next     = RUN;
          end
        end
        RUN: begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            if (remaining_reg == DUR_W'(1)) begin
              seg_done_next = 1'b1;
              // Chain straight into the next segment so velocity never dips between them.
              if (!fifo_empty) begin
                fifo_pop       = 1'b1;
                velocity_next  = fifo_head.velocity;
                remaining_next = load_duration(fifo_head.duration);
              end else begin
                velocity_next  = '0;
                remaining_next = '0;
                busy_next      = 1'b0;
                underrun_set   = 1'b1;
                state_next     = IDLE;
              end
            end else begin
              remaining_next = remaining_reg - DUR_W'(1);
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TICK_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // A fresh underrun wins over a simultaneous clear.
    underrun_next = underrun_set | (underrun_reg & ~clear_underrun);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      tick_cnt_reg  <= '0;
      remaining_reg <= '0;
      velocity_reg  <= '0;
      busy_reg      <= 1'b0;
      seg_done_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_next;
      remaining_reg <= remaining_next;
      velocity_reg  <= velocity_next;
      busy_reg      <= busy_next;
      seg_done_reg  <= seg_done_next;
      underrun_reg  <= underrun_next;
    end
  end

  assign velocity = velocity_reg;
  assign busy     = busy_reg;
  assign seg_done = seg_done_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_motion_queue.sv
// Directed bench for motion_queue with a time-based reference model and literal spot checks.
module tb_motion_queue;

  localparam int DEPTH    = 16;
  localparam int TICK_DIV = 10;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic               abort;
  logic               clear_underrun;
  logic signed [31:0] velocity;
  logic               busy;
  logic               seg_done;
  logic               underrun;
  logic [4:0]         level;

  motion_queue_if wr_bus ();

  motion_queue #(
    .DEPTH   (DEPTH),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr            (wr_bus),
    .start         (start),
    .abort         (abort),
    .clear_underrun(clear_underrun),
    .velocity      (velocity),
    .busy          (busy),
    .seg_done      (seg_done),
    .underrun      (underrun),
    .level         (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: segments end at absolute cycle numbers, not via a tick counter.
  typedef struct {
    int vel;
    int dur;
  } mseg_t;

  mseg_t  mq[$];
  mseg_t  ms;
  longint cyc;
  longint end_time;
  int     m_vel;
  bit     m_busy, m_seg_done, m_underrun;
  bit     push_ok, set_ur;
  int     sz;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      cyc = 0; end_time = 0; m_vel = 0;
      m_busy = 0; m_seg_done = 0; m_underrun = 0;
    end else begin
      cyc++;
      push_ok    = wr_bus.wr_valid && (mq.size() < DEPTH);
      sz         = mq.size();
      set_ur     = 0;
      m_seg_done = 0;
      if (abort) begin
        mq.delete();
        m_vel  = 0;
        m_busy = 0;
      end else begin
        if (!m_busy) begin
          if (start && sz > 0) begin
            ms = mq.pop_front();
            m_vel = ms.vel; m_busy = 1;
            end_time = cyc + longint'((ms.dur == 0) ? 1 : ms.dur) * TICK_DIV;
          end
        end else if (cyc == end_time) begin
          m_seg_done = 1;
          if (sz > 0) begin
            ms = mq.pop_front();
            m_vel = ms.vel;
            end_time = cyc + longint'((ms.dur == 0) ? 1 : ms.dur) * TICK_DIV;
          end else begin
            m_vel = 0; m_busy = 0; set_ur = 1;
          end
        end
        if (push_ok) begin
          ms.vel = int'(wr_bus.wr_velocity);
          ms.dur = int'(wr_bus.wr_duration);
          mq.push_back(ms);
        end
      end
      m_underrun = set_ur ? 1'b1 : (clear_underrun ? 1'b0 : m_underrun);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("velocity", velocity, m_vel);
      chk("busy", busy, m_busy);
      chk("seg_done", seg_done, m_seg_done);
      chk("underrun", underrun, m_underrun);
      chk("level", level, mq.size());
      chk("wr_ready", wr_bus.wr_ready, (mq.size() < DEPTH) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input int d);
    wr_bus.wr_valid    = 1'b1;
    wr_bus.wr_velocity = v;
    wr_bus.wr_duration = 16'(d);
    tick();
    wr_bus.wr_valid = 1'b0;
    $display("push vel=%0d dur=%0d level=%0d", v, d, level);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("start velocity=%0d busy=%0d", velocity, busy);
  endtask

  int n_a, n_b, n_sd;
  int vs[64];
  bit bs[64];

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; clear_underrun = 1'b0;
    wr_bus.wr_valid = 1'b0; wr_bus.wr_velocity = '0; wr_bus.wr_duration = '0;
    tick(); tick();
    chk("rst_velocity", velocity, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_bus.wr_ready, 1);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick();

    // Single segment, then underrun.
    push(5000, 3);
    pulse_start();
    n_a = 0; n_sd = 0;
    for (int k = 0; k < 60; k++) begin
      if (velocity == 5000) n_a++;
      if (seg_done) n_sd++;
      tick();
    end
    $display("single: cycles_at_5000=%0d seg_done=%0d underrun=%0d", n_a, n_sd, underrun);
    chk("single_hold", n_a, 30);
    chk("single_done", n_sd, 1);
    chk("single_underrun", underrun, 1);
    chk("single_busy", busy, 0);
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    chk("clear_underrun", underrun, 0);

    // Three chained segments including a zero-duration one.
    push(100, 2);
    push(-200, 1);
    push(0, 0);
    pulse_start();
    for (int k = 0; k < 45; k++) begin
      vs[k] = velocity; bs[k] = busy;
      tick();
    end
    n_a = 0; n_b = 0; n_sd = 0;
    for (int k = 0; k < 20; k++) if (vs[k] == 100) n_a++;
    for (int k = 20; k < 30; k++) if (vs[k] == -200) n_b++;
    $display("chain: n100=%0d n-200=%0d busy39=%0d busy40=%0d", n_a, n_b, bs[39], bs[40]);
    chk("chain_100", n_a, 20);
    chk("chain_m200", n_b, 10);
    chk("chain_zero_vel", vs[35], 0);
    chk("chain_busy39", bs[39], 1);
    chk("chain_busy40", bs[40], 0);
    chk("chain_underrun", underrun, 1);

    // Overfill, then pop-while-full with a rejected push.
    wr_bus.wr_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_bus.wr_velocity = 1000 + i;
      wr_bus.wr_duration = 16'd1;
      tick();
    end
    wr_bus.wr_valid = 1'b0;
    $display("fill: level=%0d wr_ready=%0d", level, wr_bus.wr_ready);
    chk("full_level", level, DEPTH);
    chk("full_ready", wr_bus.wr_ready, 0);
    wr_bus.wr_valid = 1'b1; wr_bus.wr_velocity = 77; start = 1'b1;
    tick();
    wr_bus.wr_valid = 1'b0; start = 1'b0;
    $display("pop_full: level=%0d velocity=%0d", level, velocity);
    chk("popfull_level", level, DEPTH - 1);
    chk("popfull_vel", velocity, 1000);
    repeat (25) tick();
    chk("third_seg_vel", velocity, 1002);

    // Abort mid-segment with a simultaneous push.
    abort = 1'b1; wr_bus.wr_valid = 1'b1; wr_bus.wr_velocity = 55;
    tick();
    abort = 1'b0; wr_bus.wr_valid = 1'b0;
    $display("abort: velocity=%0d level=%0d busy=%0d underrun=%0d", velocity, level, busy, underrun);
    chk("abort_vel", velocity, 0);
    chk("abort_level", level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_underrun", underrun, 1);

    // Asynchronous reset in the middle of a segment.
    push(9, 5);
    pulse_start();
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    $display("async_reset: velocity=%0d busy=%0d level=%0d underrun=%0d", velocity, busy, level, underrun);
    chk("areset_vel", velocity, 0);
    chk("areset_busy", busy, 0);
    chk("areset_level", level, 0);
    chk("areset_underrun", underrun, 0);
    chk("areset_ready", wr_bus.wr_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    pulse_start();
    chk("empty_start_busy", busy, 0);
    chk("empty_start_vel", velocity, 0);

    // Underrun set and clear in the same cycle.
    push(7, 1);
    pulse_start();
    repeat (9) tick();
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    $display("set_vs_clear: underrun=%0d seg_done=%0d", underrun, seg_done);
    chk("setclr_underrun", underrun, 1);
    chk("setclr_done", seg_done, 1);
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
    chk("late_clear", underrun, 0);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/motion_queue.md
# motion_queue

Segment sequencer directly upstream of the step generator. It buffers host-written motion segments (signed velocity plus duration) in a FIFO and presents one velocity at a time on its `velocity` output, which drives the step generator's velocity input. Each segment is held for an exact number of clock cycles. Segments chain back-to-back with no gap. On underrun or abort the output falls to zero.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `TICK_DIV`, 1000: clock cycles per duration unit (matches the step generator's 1000-cycle acceleration period).
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `wr_velocity` input 32: signed segment velocity, same scale as the step generator's velocity input.
- `wr_duration` input 16: unsigned segment length in ticks; 0 is treated as 1.
- `wr_valid` input 1: push request.
- `wr_ready` output 1: FIFO not full.
- `start` input 1: begin execution from IDLE.
- `abort` input 1: flush and stop.
- `clear_underrun` input 1: clears the sticky `underrun` flag.
- `velocity` output 32: registered signed target velocity.
- `busy` output 1: high in RUN.
- `seg_done` output 1: one-cycle pulse at each segment end.
- `underrun` output 1: sticky; set when RUN exhausts the FIFO.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Push is accepted on a rising edge when `wr_valid && wr_ready`. While full, `wr_valid` is ignored and no data changes.
- States:
  - IDLE: `velocity`=0, `busy`=0. On `start` with `level`>0: pop the head into `cur_vel`/`remaining`, clear the tick counter, go to RUN. `start` with an empty FIFO does nothing.
  - RUN:
    - `tick_cnt` counts 0..TICK_DIV-1 and wraps.
    - On each wrap, `remaining` decrements.
    - When the wrap occurs with `remaining`==1 the segment ends and `seg_done` pulses.
    - If the FIFO is non-empty at that moment, pop the next segment in the same cycle (no zero-velocity gap) and stay in RUN.
    - If the FIFO is empty, set `velocity`=0, set `underrun`, go to IDLE.
  - `start` in RUN is ignored.
- `abort`:
  - Highest priority in every state.
  - Empties the FIFO (`level`=0), sets `velocity`=0, returns to IDLE.
  - Does not pulse `seg_done` and does not set `underrun`.
  - A push in the same cycle as `abort` is discarded.
- Push and pop in the same cycle: both take effect and `level` is unchanged. `wr_ready` is computed from the pre-pop level, so a full FIFO rejects the push even while popping.
- `underrun`: set has priority over `clear_underrun` in the same cycle. Cleared only by `clear_underrun` or reset.
- Width rules:
  - `remaining` is 16 bits.
  - Duration 0 loads as 1.
  - Maximum duration 65535 ticks.
  - No arithmetic is performed on velocity; it is passed through unmodified. Clamping is done downstream.
- Reset, asynchronous: IDLE, FIFO empty, `velocity`=0, `busy`=0, `seg_done`=0, `underrun`=0, `wr_ready`=1, `level`=0, counters 0. Reset mid-segment discards everything immediately.

## Timing
- Start latency: `start` sampled at edge E → `velocity`=head value and `busy`=1 visible after E (1 cycle).
- A segment with duration D loaded at edge E remains on `velocity` for exactly D·TICK_DIV cycles. At edge E+D·TICK_DIV, `velocity` becomes the next value or 0, and `seg_done` is high for the following cycle only.
- Push-to-`level` latency: 1 cycle.
- `wr_ready` deasserts the cycle after the push that fills the FIFO.
- Abort: `velocity`=0 and `busy`=0 one cycle after `abort` is sampled.
- All outputs are registered except `wr_ready`, which is a direct decode of the registered `level`.

## Structure
- Package `motion_pkg`:
  - `VEL_W`=32, `DUR_W`=16.
  - Segment struct {velocity, duration}.
  - State enum {IDLE, RUN}.
  - Default `TICK_DIV`.
- Sub-module `seg_fifo`:
  - Synchronous FIFO of `DEPTH` segment entries.
  - Push/pop/flush ports, `level`, `full`/`empty`.
  - Wrap-around read/write pointers with an extra MSB for full/empty.
- Top level: state machine, tick divider, `remaining` counter, output registers.

## Test plan
- Push (+5000,3), then `start`, with TICK_DIV=10 → `velocity`=5000 for exactly 30 cycles, then 0, `seg_done` once, `underrun`=1, `busy`=0.
- Push (+100,2), (−200,1), (0,0), then `start` → `velocity` sequence 100×20, −200×10, 0×10 with no gaps; three `seg_done` pulses; final `underrun`=1.
- Push DEPTH+2 entries with no pops → `wr_ready`=0 after DEPTH accepts, extra pushes dropped, `level`=DEPTH. Pushing during a full-FIFO pop is rejected.
- `abort` mid-segment, with a simultaneous push → next cycle `velocity`=0, `level`=0, `busy`=0, `underrun` unchanged.
- Assert `reset_n` low asynchronously mid-RUN (between clock edges) → all outputs go to reset values immediately. After release, `start` with an empty FIFO keeps IDLE.
- `underrun` set and `clear_underrun` asserted in the same cycle → `underrun`=1. `clear_underrun` on the next cycle → `underrun`=0.
